// File: rtl/proc_pkg.sv
// Shared definitions for the proc_ctrl instruction sequencer: opcodes,
// ALU operation codes, the immediate operand select and the FSM state type.
package proc_pkg;

  localparam logic [2:0] OPC_MV  = 3'b000;
  localparam logic [2:0] OPC_MVI = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;
  localparam logic [2:0] OPC_AND = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [3:0] SEL_IMM = 4'd8;

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_e;

endpackage

// File: rtl/proc_ctrl.sv
// Multi-cycle control unit for a small register-file processor: mv/mvi in one
// execute cycle, add/sub(/and) in three. Define PROC_CTRL_AND_EN to enable opcode 100 as and.
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int REG_N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [OP_W+5:0]   instr,
  output logic [3:0]        sel,
  output logic [REG_N-1:0]  r_in,
  output logic              a_in,
  output logic              g_in,
  output logic [1:0]        alu_op,
  output logic              wb_alu,
  output logic              done,
  output logic              busy,
  output logic              err
);

  state_e            state_q, state_d;
  logic [OP_W+5:0]   ir_q, ir_d;

  logic [OP_W-1:0]   op_d;
  logic [2:0]        rx_d, ry_d;
  logic [REG_N-1:0]  rx_onehot;

  logic [3:0]        sel_d;
  logic [REG_N-1:0]  r_in_d;
  logic              a_in_d, g_in_d, wb_alu_d, done_d, err_d;
  logic [1:0]        alu_op_d;

  function automatic logic is_alu(input logic [OP_W-1:0] op);
`ifdef PROC_CTRL_AND_EN
    return (op == OP_W'(OPC_ADD)) || (op == OP_W'(OPC_SUB)) || (op == OP_W'(OPC_AND));
`else
    return (op == OP_W'(OPC_ADD)) || (op == OP_W'(OPC_SUB));
`endif
  endfunction

  function automatic logic [1:0] alu_code(input logic [OP_W-1:0] op);
    if (op == OP_W'(OPC_SUB)) return ALU_SUB;
`ifdef PROC_CTRL_AND_EN
    if (op == OP_W'(OPC_AND)) return ALU_AND;
`endif
    return ALU_ADD;
  endfunction

  // Next-state and instruction capture; run is only looked at in IDLE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: if (run) begin
        state_d = T1;
        ir_d    = instr;
      end
      T1:      state_d = is_alu(ir_q[OP_W+5:6]) ? T2 : IDLE;
      T2:      state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign op_d = ir_d[OP_W+5:6];
  assign rx_d = ir_d[5:3];
  assign ry_d = ir_d[2:0];

  always_comb begin
    rx_onehot       = '0;
    rx_onehot[rx_d] = 1'b1;
  end

  // Outputs for the cycle the FSM is about to enter, so they come straight from flops.
  always_comb begin
    sel_d    = '0;
    r_in_d   = '0;
    a_in_d   = 1'b0;
    g_in_d   = 1'b0;
    alu_op_d = ALU_ADD;
    wb_alu_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_d)
      T1: begin
        if (op_d == OP_W'(OPC_MV)) begin
          sel_d  = {1'b0, ry_d};
          r_in_d = rx_onehot;
          done_d = 1'b1;
        end else if (op_d == OP_W'(OPC_MVI)) begin
          sel_d  = SEL_IMM;
          r_in_d = rx_onehot;
          done_d = 1'b1;
        end else if (is_alu(op_d)) begin
          sel_d  = {1'b0, rx_d};
          a_in_d = 1'b1;
        end else begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      T2: begin
        sel_d    = {1'b0, ry_d};
        g_in_d   = 1'b1;
        alu_op_d = alu_code(op_d);
      end
      T3: begin
        wb_alu_d = 1'b1;
        r_in_d   = rx_onehot;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      sel     <= '0;
      r_in    <= '0;
      a_in    <= 1'b0;
      g_in    <= 1'b0;
      alu_op  <= ALU_ADD;
      wb_alu  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sel     <= sel_d;
      r_in    <= r_in_d;
      a_in    <= a_in_d;
      g_in    <= g_in_d;
      alu_op  <= alu_op_d;
      wb_alu  <= wb_alu_d;
      done    <= done_d;
      busy    <= (state_d != IDLE);
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed scenarios followed by random
// run/instr/rst traffic, compared each cycle against a schedule-based model.
module tb_proc_ctrl;

  logic       clk = 1'b0;
  logic       rst, run;
  logic [8:0] instr;
  logic [3:0] sel;
  logic [7:0] r_in;
  logic       a_in, g_in, wb_alu, done, busy, err;
  logic [1:0] alu_op;

  int total = 0;
  int bad   = 0;

  typedef logic [19:0] obs_t;

  obs_t exp_q[$];
  obs_t cur_exp = '0;
  obs_t dut_obs;

  proc_ctrl #(.OP_W(3), .REG_N(8)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr),
    .sel(sel), .r_in(r_in), .a_in(a_in), .g_in(g_in), .alu_op(alu_op),
    .wb_alu(wb_alu), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign dut_obs = {sel, r_in, a_in, g_in, alu_op, wb_alu, done, busy, err};

  function automatic obs_t mk(input int s, input int rin, input bit a, input bit g,
                              input int op, input bit wb, input bit dn, input bit bz, input bit er);
    return {4'(s), 8'(rin), a, g, 2'(op), wb, dn, bz, er};
  endfunction

  // Expected per-cycle outputs of one instruction, from the instruction-level rules.
  task automatic push_instr(input logic [8:0] ins);
    int op, rx, ry;
    bit alu;
    int aop;
    op  = int'(ins[8:6]);
    rx  = int'(ins[5:3]);
    ry  = int'(ins[2:0]);
    alu = (op == 2) || (op == 3);
    aop = (op == 3) ? 1 : 0;
`ifdef PROC_CTRL_AND_EN
    if (op == 4) begin alu = 1'b1; aop = 2; end
`endif
    if (op == 0)
      exp_q.push_back(mk(ry, 1 << rx, 0, 0, 0, 0, 1, 1, 0));
    else if (op == 1)
      exp_q.push_back(mk(8, 1 << rx, 0, 0, 0, 0, 1, 1, 0));
    else if (alu) begin
      exp_q.push_back(mk(rx, 0, 1, 0, 0, 0, 0, 1, 0));
      exp_q.push_back(mk(ry, 0, 0, 1, aop, 0, 0, 1, 0));
      exp_q.push_back(mk(0, 1 << rx, 0, 0, 0, 1, 1, 1, 0));
    end else
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
  endtask

  task automatic check(input string tag, input obs_t o, input obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input bit r, input bit rn, input logic [8:0] ins, input string tag);
    rst   = r;
    run   = rn;
    instr = ins;
    if (r) begin
      exp_q.delete();
      cur_exp = '0;
    end else begin
      if (!cur_exp[1] && rn) push_instr(ins);
      cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    end
    @(posedge clk);
    #1;
    check(tag, dut_obs, cur_exp);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr = '0;
    step(1, 0, 9'h000, "reset0");
    step(1, 1, 9'h1ff, "reset1");
    check("reset_const", dut_obs, '0);

    step(0, 1, 9'b001_010_000, "mvi_t1");
    check("mvi_const", dut_obs, mk(8, 8'h04, 0, 0, 0, 0, 1, 1, 0));
    step(0, 0, 9'h000, "mvi_idle");

    step(0, 1, 9'b000_101_001, "mv_t1");
    check("mv_const", dut_obs, mk(1, 8'h20, 0, 0, 0, 0, 1, 1, 0));
    step(0, 0, 9'h000, "mv_idle");
    step(0, 1, 9'b000_011_011, "mv_self_t1");
    step(0, 0, 9'h000, "mv_self_idle");

    step(0, 1, 9'b011_000_111, "sub_t1");
    step(0, 0, 9'h000, "sub_t2");
    check("sub_t2_const", dut_obs, mk(7, 0, 0, 1, 1, 0, 0, 1, 0));
    step(0, 0, 9'h000, "sub_t3");
    check("sub_t3_const", dut_obs, mk(0, 8'h01, 0, 0, 0, 1, 1, 1, 0));
    step(0, 0, 9'h000, "sub_idle");

    step(0, 1, 9'b111_010_001, "op7_t1");
    check("op7_const", dut_obs, mk(0, 0, 0, 0, 0, 0, 1, 1, 1));
    step(0, 0, 9'h000, "op7_idle");

    step(0, 1, 9'b100_110_010, "op4_t1");
    step(0, 0, 9'h000, "op4_next1");
    step(0, 0, 9'h000, "op4_next2");
    step(0, 0, 9'h000, "op4_next3");

    step(0, 1, 9'b010_001_010, "rst_add_t1");
    step(0, 0, 9'h000, "rst_add_t2");
    step(1, 0, 9'h000, "rst_add_abort");
    step(0, 0, 9'h000, "rst_add_idle1");
    step(0, 0, 9'h000, "rst_add_idle2");

    step(0, 1, 9'b010_100_101, "pulse_t1");
    step(0, 0, 9'h000, "pulse_t2");
    step(0, 1, 9'b001_111_000, "pulse_t3");
    step(0, 0, 9'h000, "pulse_idle1");
    step(0, 0, 9'h000, "pulse_idle2");

    for (int i = 0; i < 8; i++)
      step(0, 1, {3'b000, 3'(i), 3'(7 - i)}, "b2b_mv");
    step(0, 0, 9'h000, "b2b_end");

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
           9'($urandom_range(0, 511)), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 3: opcode field width.
REQ-002 SHALL have parameter REG_N, default 8: number of general registers; register index width is 3.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: start request, sampled only in IDLE.
REQ-006 SHALL have port instr, input, 9 bits: [8:6] opcode, [5:3] rx (destination), [2:0] ry (source).
REQ-007 SHALL have port sel, output, 4 bits: datapath operand select; 0-7 select R0-R7, 8 selects immediate.
REQ-008 SHALL have port r_in, output, 8 bits: one-hot register write enable.
REQ-009 SHALL have port a_in, output, 1 bit: ALU A-operand latch enable.
REQ-010 SHALL have port g_in, output, 1 bit: ALU result register G load enable.
REQ-011 SHALL have port alu_op, output, 2 bits: 00 add, 01 sub, 10 and.
REQ-012 SHALL have port wb_alu, output, 1 bit: register write data comes from G rather than the mux.
REQ-013 SHALL have ports done (1 bit), busy (1 bit) and err (1 bit), all outputs: done is the completion pulse, busy means state is not IDLE, err is the illegal-opcode pulse.

Function
REQ-014 SHALL implement states IDLE, T1, T2 and T3 in a registered state variable.
REQ-015 In IDLE with run=1, SHALL capture instr into the internal IR and go to T1; with run=0, SHALL stay in IDLE.
REQ-016 SHALL decode all outputs from the registered state and IR only; there SHALL be no combinational path from run or instr to any output.
REQ-017 In IDLE, SHALL drive sel=0, r_in=0, a_in=g_in=wb_alu=done=err=0 and alu_op=00.
REQ-018 In T1 for mv (000), SHALL drive sel=ry, r_in[rx]=1 and done=1, then go to IDLE.
REQ-019 In T1 for mvi (001), SHALL drive sel=8, r_in[rx]=1 and done=1, then go to IDLE.
REQ-020 In T1 for add (010), sub (011) or and (100, see REQ-029), SHALL drive sel=rx and a_in=1, then go to T2.
REQ-021 In T2, SHALL drive sel=ry, g_in=1 and alu_op per the opcode, then go to T3.
REQ-022 In T3, SHALL drive wb_alu=1, r_in[rx]=1 and done=1, then go to IDLE.
REQ-023 For an illegal opcode in T1, SHALL drive done=1 and err=1 with no enables asserted, then go to IDLE.
REQ-024 Latency: mv and mvi SHALL raise done in the second cycle after run is sampled; ALU operations SHALL raise done in the fourth.
REQ-025 run asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-026 r_in SHALL be one-hot or zero in every cycle; rx=ry SHALL be legal (for example, mv R3,R3 writes R3 from itself).
REQ-027 Back-to-back operation: with run held at 1, a new instruction SHALL be captured in the IDLE cycle following done.

Reset
REQ-028 rst=1 at a clock edge SHALL force state to IDLE and IR to 0, whether idle or mid-instruction. No enable SHALL be asserted on the following cycle, and an aborted instruction SHALL produce no done.

Configuration
REQ-029 Macro PROC_CTRL_AND_EN:
  - when defined, opcode 100 SHALL execute as and (alu_op=10);
  - when undefined, opcode 100 SHALL be illegal per REQ-023, and alu_op SHALL never be 10.

Structure
REQ-030 A shared package proc_pkg SHALL hold the opcode constants, the alu_op constants, SEL_IMM=4'd8 and the state enum.
REQ-031 SHALL contain no sub-module; the 3-to-8 one-hot decode of rx SHALL be inline logic.

Verification
REQ-032 Reset then mvi R2: run=1 with instr=001_010_000 -> in T1, sel=8, r_in=8'h04 and done=1; busy=0 on the next cycle.
REQ-033 mv R5,R1 (000_101_001) -> T1 drives sel=1, r_in=8'h20 and done=1; done is at cycle 2 after run.
REQ-034 sub R0,R7 (011_000_111) -> T1: sel=0, a_in=1; T2: sel=7, g_in=1, alu_op=01; T3: wb_alu=1, r_in=8'h01, done=1.
REQ-035 Opcode 111 -> T1 drives done=1, err=1 and r_in=0. Opcode 100 behaves the same without PROC_CTRL_AND_EN, and with the macro defined runs the add-like sequence with alu_op=10.
REQ-036 rst=1 in T2 of an add -> next cycle is IDLE with all enables 0, and no done is produced.
REQ-037 Pulse run during T2 of an add -> the pulse is ignored; only one done is produced, and the state returns to IDLE until run is asserted again.
